multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/lc2k_pkg.sv | 27 ++
 rtl/mem_wait_timer.sv | 25 ++
 rtl/multicycle_control.sv | 107 ++++++++++
 tb/tb_multicycle_control.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared opcodes, FSM states and datapath select encodings for the LC-2K control unit
package lc2k_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED, FAULT} state_e;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_NOR = 2'd1;
    localparam logic [1:0] ALU_CMP = 2'd2;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_REG = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC1 = 2'd2;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive stalled memory cycles and flags the cycle the limit is reached
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);
    localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    logic [W-1:0] cnt_q;
    logic         stall;

    assign stall = req_i && !ready_i;
    // Fires on the MEM_TIMEOUT-th stalled cycle; the FSM lets a same-cycle ready take priority.
    assign timeout_o = (MEM_TIMEOUT > 0) && req_i && (cnt_q == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || !stall) cnt_q <= '0;
        else if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: LC-2K multicycle FSM driving memory, IR, PC, register file and ALU controls
module multicycle_control
    import lc2k_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  opcode,
    input  logic        alu_eq,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        write_reg_sel,
    output logic [1:0]  write_data_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);
    state_e      state_q, state_d;
    logic [31:0] count_q;
    logic        timeout;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .req_i    (mem_req),
        .ready_i  (mem_ready),
        .timeout_o(timeout)
    );

    // Strobes are decoded from state and gated by reset so an in-flight access drops immediately.
    always_comb begin
        state_d        = state_q;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr_sel   = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = PC_INC;
        reg_write      = 1'b0;
        write_reg_sel  = 1'b0;
        write_data_sel = WD_ALU;
        alu_src_b      = 1'b0;
        alu_op         = ALU_ADD;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    state_d  = mem_ready ? DECODE : timeout ? FAULT : FETCH;
                end
                DECODE: begin
                    pc_write = opcode == OP_NOOP;
                    state_d  = opcode == OP_HALT ? HALTED :
                               opcode == OP_JALR ? WB :
                               opcode == OP_NOOP ? FETCH : EXEC;
                end
                EXEC: begin
                    alu_op    = opcode == OP_NOR ? ALU_NOR : opcode == OP_BEQ ? ALU_CMP : ALU_ADD;
                    alu_src_b = opcode == OP_LW || opcode == OP_SW;
                    pc_write  = opcode == OP_BEQ;
                    pc_src    = (opcode == OP_BEQ && alu_eq) ? PC_BR : PC_INC;
                    state_d   = opcode == OP_BEQ ? FETCH : alu_src_b ? MEM : WB;
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = opcode == OP_SW;
                    pc_write     = mem_ready && opcode == OP_SW;
                    state_d      = mem_ready ? (opcode == OP_SW ? FETCH : WB) : timeout ? FAULT : MEM;
                end
                WB: begin
                    reg_write      = 1'b1;
                    pc_write       = 1'b1;
                    write_reg_sel  = opcode == OP_ADD || opcode == OP_NOR;
                    write_data_sel = opcode == OP_LW ? WD_MEM : opcode == OP_JALR ? WD_PC1 : WD_ALU;
                    pc_src         = opcode == OP_JALR ? PC_REG : PC_INC;
                    state_d        = FETCH;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_write || (state_d == HALTED && state_q != HALTED)) count_q <= count_q + 32'd1;
        end
    end

    assign halted      = state_q == HALTED;
    assign fault       = state_q == FAULT;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed stimulus with hand-computed control vectors for multicycle_control
module tb_multicycle_control;
    import lc2k_pkg::*;

    logic        clk, reset, alu_eq, mem_ready;
    logic [2:0]  opcode;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, write_reg_sel, alu_src_b;
    logic [1:0]  pc_src, write_data_sel, alu_op;
    logic        halted, fault;
    logic [31:0] instr_count;
    logic [13:0] outs;
    int          n_cmp = 0;
    int          n_err = 0;

    // {req, we, addr_sel, ir_w, pc_w, pc_src, reg_w, wr_sel, wd_sel, srcb, alu_op}
    localparam logic [13:0] V_ZERO     = 14'b0_0_0_0_0_00_0_0_00_0_00;
    localparam logic [13:0] FETCH_RDY  = 14'b1_0_0_1_0_00_0_0_00_0_00;
    localparam logic [13:0] FETCH_WAIT = 14'b1_0_0_0_0_00_0_0_00_0_00;
    localparam logic [13:0] DEC_NOOP   = 14'b0_0_0_0_1_00_0_0_00_0_00;
    localparam logic [13:0] EX_NOR     = 14'b0_0_0_0_0_00_0_0_00_0_01;
    localparam logic [13:0] EX_MEM     = 14'b0_0_0_0_0_00_0_0_00_1_00;
    localparam logic [13:0] EX_BEQ1    = 14'b0_0_0_0_1_01_0_0_00_0_10;
    localparam logic [13:0] EX_BEQ0    = 14'b0_0_0_0_1_00_0_0_00_0_10;
    localparam logic [13:0] MEM_LW     = 14'b1_0_1_0_0_00_0_0_00_0_00;
    localparam logic [13:0] MEM_SW_W   = 14'b1_1_1_0_0_00_0_0_00_0_00;
    localparam logic [13:0] MEM_SW     = 14'b1_1_1_0_1_00_0_0_00_0_00;
    localparam logic [13:0] WB_ALU     = 14'b0_0_0_0_1_00_1_1_00_0_00;
    localparam logic [13:0] WB_LW      = 14'b0_0_0_0_1_00_1_0_01_0_00;
    localparam logic [13:0] WB_JALR    = 14'b0_0_0_0_1_10_1_0_10_0_00;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_eq(alu_eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .write_reg_sel(write_reg_sel),
        .write_data_sel(write_data_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    assign outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                   reg_write, write_reg_sel, write_data_sel, alu_src_b, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [13:0] e);
        #1;
        chk(tag, {18'd0, outs}, {18'd0, e});
        cyc();
    endtask

    initial begin
        reset = 1'b1; opcode = OP_NOOP; alu_eq = 1'b0; mem_ready = 1'b1;
        cyc(); cyc();
        #1;
        chk("rst_strobes", {18'd0, outs}, {18'd0, V_ZERO});
        chk("rst_count", instr_count, 32'd0);
        chk("rst_flags", {30'd0, halted, fault}, 32'd0);
        reset = 1'b0;
        step("add_fetch", FETCH_RDY);
        opcode = OP_ADD;
        step("add_dec", V_ZERO);
        step("add_exec", V_ZERO);
        step("add_wb", WB_ALU);
        chk("add_count", instr_count, 32'd1);
        step("nor_fetch", FETCH_RDY);
        opcode = OP_NOR;
        step("nor_dec", V_ZERO);
        step("nor_exec", EX_NOR);
        step("nor_wb", WB_ALU);
        chk("nor_count", instr_count, 32'd2);
        step("lw_fetch", FETCH_RDY);
        opcode = OP_LW;
        step("lw_dec", V_ZERO);
        step("lw_exec", EX_MEM);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", MEM_LW);
        mem_ready = 1'b1;
        step("lw_mem_rdy", MEM_LW);
        step("lw_wb", WB_LW);
        chk("lw_count", instr_count, 32'd3);
        step("sw_fetch", FETCH_RDY);
        opcode = OP_SW;
        step("sw_dec", V_ZERO);
        step("sw_exec", EX_MEM);
        mem_ready = 1'b0;
        step("sw_wait", MEM_SW_W);
        reset = 1'b1;
        step("sw_rst", V_ZERO);
        reset = 1'b0;
        mem_ready = 1'b1;
        step("sw_refetch", FETCH_RDY);
        chk("sw_rst_count", instr_count, 32'd0);
        opcode = OP_SW;
        step("sw2_dec", V_ZERO);
        step("sw2_exec", EX_MEM);
        step("sw2_mem", MEM_SW);
        chk("sw2_count", instr_count, 32'd1);
        step("beq1_fetch", FETCH_RDY);
        opcode = OP_BEQ; alu_eq = 1'b1;
        step("beq1_dec", V_ZERO);
        step("beq1_exec", EX_BEQ1);
        chk("beq1_count", instr_count, 32'd2);
        step("beq0_fetch", FETCH_RDY);
        alu_eq = 1'b0;
        step("beq0_dec", V_ZERO);
        step("beq0_exec", EX_BEQ0);
        chk("beq0_count", instr_count, 32'd3);
        step("noop_fetch", FETCH_RDY);
        opcode = OP_NOOP;
        step("noop_dec", DEC_NOOP);
        chk("noop_count", instr_count, 32'd4);
        reset = 1'b1;
        step("rst2", V_ZERO);
        reset = 1'b0;
        chk("rst2_count", instr_count, 32'd0);
        step("jalr_fetch", FETCH_RDY);
        opcode = OP_JALR;
        step("jalr_dec", V_ZERO);
        step("jalr_wb", WB_JALR);
        chk("jalr_count", instr_count, 32'd1);
        step("halt_fetch", FETCH_RDY);
        opcode = OP_HALT;
        step("halt_dec", V_ZERO);
        chk("halted_flag", {31'd0, halted}, 32'd1);
        chk("halt_count", instr_count, 32'd2);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            opcode = 3'(i);
            step("halted_hold", V_ZERO);
            chk("halted_frozen", instr_count, 32'd2);
        end
        chk("halted_still", {31'd0, halted}, 32'd1);
        reset = 1'b1;
        step("halt_rst", V_ZERO);
        chk("halt_rst_flag", {31'd0, halted}, 32'd0);
        chk("halt_rst_count", instr_count, 32'd0);
        reset = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("to_wait", FETCH_WAIT);
        chk("to_fault", {31'd0, fault}, 32'd1);
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) step("fault_hold", V_ZERO);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_count", instr_count, 32'd0);
        reset = 1'b1;
        step("fault_rst", V_ZERO);
        chk("fault_rst_flag", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("edge_wait", FETCH_WAIT);
        mem_ready = 1'b1;
        step("edge_rdy", FETCH_RDY);
        chk("edge_no_fault", {31'd0, fault}, 32'd0);
        opcode = OP_ADD;
        step("edge_dec", V_ZERO);
        step("edge_exec", V_ZERO);
        step("edge_wb", WB_ALU);
        chk("edge_count", instr_count, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
